mem_xfer_engine: RTL and testbench

Bus-initiator front end for the single-port Memory block: it drives the Memory's write-enable, address and write-data inputs and consumes its read data. On a command it performs a block COPY, FILL or CHECK across the memory, one word at a time. It sits between the microprocessor control path and the Memory, and is the master of the Memory port while busy.

---
 rtl/mem_xfer_pkg.sv | 21 ++
 rtl/mem_xfer_engine.sv | 178 +++++++++++++++++
 tb/tb_mem_xfer_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared types for the memory transfer engine: command opcodes and FSM states.
package mem_xfer_pkg;

  typedef enum logic [1:0] {
    OP_COPY  = 2'd0,
    OP_FILL  = 2'd1,
    OP_CHECK = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_FILL,
    ST_CMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_xfer_engine.sv
// Bus-initiator front end for a single-port memory: block COPY, FILL and CHECK,
// one word at a time, with all memory-side outputs driven from registers.
module mem_xfer_engine
  import mem_xfer_pkg::*;
#(
  parameter  int DATA_LENGTH = 32,
  parameter  int MEM_LENGTH  = 32,
  localparam int ADDR_W      = $clog2(MEM_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [ADDR_W-1:0]      src_addr,
  input  logic [ADDR_W-1:0]      dst_addr,
  input  logic [ADDR_W:0]        len,
  input  logic [DATA_LENGTH-1:0] pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_W:0]        mismatch_cnt,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  input  logic [DATA_LENGTH-1:0] mem_rdata
);

  localparam logic [ADDR_W+1:0] MEM_LIMIT = (ADDR_W+2)'(MEM_LENGTH);

  state_e                 state_reg;
  op_e                    op_reg;
  logic [ADDR_W-1:0]      src_reg;
  logic [ADDR_W-1:0]      dst_reg;
  logic [ADDR_W:0]        len_reg;
  logic [DATA_LENGTH-1:0] pattern_reg;
  logic [ADDR_W:0]        idx_reg;

  op_e               op_in;
  logic [ADDR_W+1:0] src_end;
  logic [ADDR_W+1:0] dst_end;
  logic              bad_cmd;
  logic [ADDR_W:0]   idx_next;
  logic              last_word;
  logic [ADDR_W-1:0] src_next_addr;
  logic [ADDR_W-1:0] dst_next_addr;
  logic [ADDR_W-1:0] dst_cur_addr;

  // Range sums carry two extra bits so an out-of-range request can never wrap into range.
  assign op_in   = op_e'(op);
  assign src_end = {2'b00, src_addr} + {1'b0, len};
  assign dst_end = {2'b00, dst_addr} + {1'b0, len};
  assign bad_cmd = (op_in == OP_RSVD)
                || (((op_in == OP_COPY) || (op_in == OP_CHECK)) && (src_end > MEM_LIMIT))
                || (((op_in == OP_COPY) || (op_in == OP_FILL))  && (dst_end > MEM_LIMIT));

  assign idx_next      = idx_reg + 1'b1;
  assign last_word     = (idx_next == len_reg);
  assign src_next_addr = src_reg + idx_next[ADDR_W-1:0];
  assign dst_next_addr = dst_reg + idx_next[ADDR_W-1:0];
  assign dst_cur_addr  = dst_reg + idx_reg[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_COPY;
      src_reg      <= '0;
      dst_reg      <= '0;
      len_reg      <= '0;
      pattern_reg  <= '0;
      idx_reg      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mismatch_cnt <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg       <= op_in;
            src_reg      <= src_addr;
            dst_reg      <= dst_addr;
            len_reg      <= len;
            pattern_reg  <= pattern;
            idx_reg      <= '0;
            mismatch_cnt <= '0;
            err          <= 1'b0;
            if (bad_cmd) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
              err       <= 1'b1;
            end else if (len == '0) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
            end else if (op_in == OP_FILL) begin
              state_reg <= ST_FILL;
              busy      <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= dst_addr;
              mem_wdata <= pattern;
            end else begin
              state_reg <= ST_RD;
              busy      <= 1'b1;
              mem_addr  <= src_addr;
            end
          end
        end

        ST_RD: begin
          state_reg <= (op_reg == OP_COPY) ? ST_WAIT : ST_CMP;
        end

        // mem_wdata doubles as the copy buffer: read data lands straight in it.
        ST_WAIT: begin
          state_reg <= ST_WR;
          mem_addr  <= dst_cur_addr;
          mem_wdata <= mem_rdata;
          mem_we    <= 1'b1;
        end

        ST_WR: begin
          mem_we <= 1'b0;
          if (last_word) begin
            state_reg <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_reg <= ST_RD;
            idx_reg   <= idx_next;
            mem_addr  <= src_next_addr;
          end
        end

        ST_FILL: begin
          if (last_word) begin
            state_reg <= ST_DONE;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            idx_reg  <= idx_next;
            mem_addr <= dst_next_addr;
          end
        end

        ST_CMP: begin
          if (mem_rdata != pattern_reg) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
          end
          if (last_word) begin
            state_reg <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_reg <= ST_RD;
            idx_reg   <= idx_next;
            mem_addr  <= src_next_addr;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          done      <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Directed bench for mem_xfer_engine with a registered-read memory model on its port.
module tb_mem_xfer_engine;

  localparam int DL = 32;
  localparam int ML = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   len;
  logic [DL-1:0] pattern;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   mismatch_cnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DL-1:0] mem_wdata;
  logic [DL-1:0] mem_rdata;

  logic [DL-1:0] mem [0:ML-1];

  int n_checks = 0;
  int n_errors = 0;

  int busy_n, we_n, done_n, lat, err_d, mm_d;
  int we_addr [0:15];

  always #5 clk = ~clk;

  mem_xfer_engine #(.DATA_LENGTH(DL), .MEM_LENGTH(ML)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
    .pattern      (pattern),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mismatch_cnt (mismatch_cnt),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues one command and observes it until a few cycles past done.
  task automatic run_cmd(input logic [1:0] c_op, input int c_src, input int c_dst,
                         input int c_len, input logic [DL-1:0] c_pat, input int inject_at);
    busy_n = 0; we_n = 0; done_n = 0; lat = 0; err_d = 0; mm_d = 0;
    for (int k = 0; k < 16; k++) we_addr[k] = -1;
    op = c_op; src_addr = AW'(c_src); dst_addr = AW'(c_dst);
    len = (AW+1)'(c_len); pattern = c_pat; start = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == inject_at) begin
        op = 2'd1; dst_addr = 5'd20; len = 6'd2; pattern = 32'hDEAD; start = 1'b1;
      end
      if (cyc == inject_at + 1) start = 1'b0;
      if (busy) busy_n++;
      if (mem_we) begin
        if (we_n < 16) we_addr[we_n] = int'(mem_addr);
        we_n++;
      end
      if (done) begin
        done_n++;
        if (lat == 0) begin
          lat = cyc; err_d = int'(err); mm_d = int'(mismatch_cnt);
        end
      end
      if (lat != 0 && cyc >= lat + 3) break;
    end
    start = 1'b0;
    if (lat == 0) chk("timeout_waiting_done", 64'd0, 64'd1);
    $display("cmd op=%0d src=%0d dst=%0d len=%0d: busy=%0d we=%0d done=%0d lat=%0d err=%0d mm=%0d",
             c_op, c_src, c_dst, c_len, busy_n, we_n, done_n, lat, err_d, mm_d);
  endtask

  initial begin
    for (int k = 0; k < ML; k++) mem[k] = '0;
    rst = 1'b1; start = 1'b0; op = '0; src_addr = '0; dst_addr = '0; len = '0; pattern = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_mm",    mismatch_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // FILL dst=4 len=3
    run_cmd(2'd1, 0, 4, 3, 32'hA5A5A5A5, 0);
    chk("fill_busy", busy_n, 3);
    chk("fill_we",   we_n, 3);
    chk("fill_a0",   we_addr[0], 4);
    chk("fill_a1",   we_addr[1], 5);
    chk("fill_a2",   we_addr[2], 6);
    chk("fill_lat",  lat, 4);
    chk("fill_done", done_n, 1);
    chk("fill_err",  err_d, 0);
    chk("fill_m4",   mem[4], 32'hA5A5A5A5);
    chk("fill_m5",   mem[5], 32'hA5A5A5A5);
    chk("fill_m6",   mem[6], 32'hA5A5A5A5);
    chk("fill_m7",   mem[7], 32'h0);

    // COPY 0..3 -> 16..19
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    run_cmd(2'd0, 0, 16, 4, 32'h0, 0);
    chk("copy_busy", busy_n, 12);
    chk("copy_we",   we_n, 4);
    chk("copy_done", done_n, 1);
    chk("copy_err",  err_d, 0);
    chk("copy_a0",   we_addr[0], 16);
    chk("copy_a3",   we_addr[3], 19);
    chk("copy_m16",  mem[16], 32'h11);
    chk("copy_m17",  mem[17], 32'h22);
    chk("copy_m18",  mem[18], 32'h33);
    chk("copy_m19",  mem[19], 32'h44);

    // CHECK with one corrupted word
    mem[5] = 32'h0;
    run_cmd(2'd2, 4, 0, 3, 32'hA5A5A5A5, 0);
    chk("check_busy", busy_n, 6);
    chk("check_we",   we_n, 0);
    chk("check_err",  err_d, 0);
    chk("check_mm",   mm_d, 1);
    chk("check_done", done_n, 1);

    // Rejected and empty commands
    run_cmd(2'd0, 30, 0, 4, 32'h0, 0);
    chk("oor_lat", lat, 1);
    chk("oor_err", err_d, 1);
    chk("oor_we",  we_n, 0);
    chk("oor_busy", busy_n, 0);
    run_cmd(2'd3, 0, 0, 1, 32'h0, 0);
    chk("rsvd_err", err_d, 1);
    chk("rsvd_we",  we_n, 0);
    run_cmd(2'd1, 0, 0, 0, 32'h5, 0);
    chk("len0_lat", lat, 1);
    chk("len0_err", err_d, 0);
    chk("len0_we",  we_n, 0);

    // start pulsed mid-COPY must be ignored
    run_cmd(2'd0, 0, 24, 2, 32'h0, 2);
    chk("inj_done", done_n, 1);
    chk("inj_busy", busy_n, 6);
    chk("inj_we",   we_n, 2);
    chk("inj_m24",  mem[24], 32'h11);
    chk("inj_m25",  mem[25], 32'h22);
    chk("inj_m20",  mem[20], 32'h0);

    // Reset in the middle of a FILL
    op = 2'd1; dst_addr = 5'd8; len = 6'd8; pattern = 32'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_we_before", mem_we, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_we_after",   mem_we, 0);
    chk("mid_busy_after", busy, 0);
    chk("mid_done_after", done, 0);
    rst = 1'b0;
    done_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || mem_we) done_n++;
    end
    chk("mid_quiet", done_n, 0);

    // Fresh FILL ending exactly at the top of memory
    run_cmd(2'd1, 0, 28, 4, 32'h99, 0);
    chk("post_busy", busy_n, 4);
    chk("post_we",   we_n, 4);
    chk("post_err",  err_d, 0);
    chk("post_done", done_n, 1);
    chk("post_m31",  mem[31], 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
